// File: rtl/fb_pixel_writer.sv
// Pixel sink: buffers in-range (DrawX, DrawY) pixels in a FIFO and writes them to the frame buffer over a req/ack port.
// Also runs a full-frame clear. Optional macro FB_DEDUP_EN drops a pixel that repeats the previous pixel's address.
module fb_pixel_writer #(
    parameter int unsigned H_RES      = 640,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned COLOR_W    = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               pixel_valid,
    output logic               pixel_ready,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic [COLOR_W-1:0] pixel_color,
    input  logic               clear_start,
    input  logic [COLOR_W-1:0] clear_color,
    output logic               clear_done,
    output logic               busy,
    output logic               mem_req,
    output logic [18:0]        mem_addr,
    output logic [COLOR_W-1:0] mem_wdata,
    input  logic               mem_ack
);

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR, DONE} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
    } entry_t;

    state_t             state, state_nx;
    entry_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [ADDR_W-1:0]  pix_addr;
    logic               in_range, dup, push, pop, clr_begin, clr_step, fifo_empty;

    assign pix_addr   = ADDR_W'(DrawY) * ADDR_W'(H_RES) + ADDR_W'(DrawX);
    assign in_range   = (32'(DrawX) < H_RES) && (32'(DrawY) < V_RES);
    assign fifo_empty = (cnt == '0);
    assign push       = pixel_valid && pixel_ready && in_range && !dup;
    assign cnt_nx     = cnt + CNT_W'(push) - CNT_W'(pop);

`ifdef FB_DEDUP_EN
    logic [ADDR_W-1:0] last_addr;
    logic              last_valid;

    assign dup = last_valid && (last_addr == pix_addr);

    // Last accepted in-range address; forgotten when a clear begins.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            last_valid <= 1'b0;
            last_addr  <= '0;
        end else if (clr_begin) begin
            last_valid <= 1'b0;
        end else if (pixel_valid && pixel_ready && in_range) begin
            last_valid <= 1'b1;
            last_addr  <= pix_addr;
        end
    end
`else
    assign dup = 1'b0;
`endif

    // Next-state and FIFO/counter control.
    always_comb begin
        state_nx  = state;
        pop       = 1'b0;
        clr_begin = 1'b0;
        clr_step  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = WRITE;
                end else if (clear_start) begin
                    clr_begin = 1'b1;
                    state_nx  = CLEAR;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    if (!fifo_empty) pop = 1'b1;
                    else             state_nx = IDLE;
                end
            end
            CLEAR: begin
                if (mem_ack) begin
                    clr_step = 1'b1;
                    if (mem_addr == LAST_ADDR) state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (push) fifo_mem[wr_ptr] <= '{addr: pix_addr, color: pixel_color};
    end

    // State, pointers and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            pixel_ready <= 1'b1;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            clear_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            pixel_ready <= (cnt_nx != FULL_CNT) && (state_nx != CLEAR);
            mem_req     <= (state_nx == WRITE) || (state_nx == CLEAR);
            clear_done  <= (state_nx == DONE);
            busy        <= (cnt_nx != '0) || (state_nx != IDLE);
            if (pop) begin
                mem_addr  <= fifo_mem[rd_ptr].addr;
                mem_wdata <= fifo_mem[rd_ptr].color;
            end else if (clr_begin) begin
                mem_addr  <= '0;
                mem_wdata <= clear_color;
            end else if (clr_step) begin
                mem_addr  <= mem_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer (640x48 frame keeps the clear short); expectations follow FB_DEDUP_EN.
module tb_fb_pixel_writer;

    localparam int unsigned H_RES = 640;
    localparam int unsigned V_RES = 48;
    localparam int unsigned NPIX  = H_RES * V_RES;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        pixel_valid = 1'b0;
    logic        pixel_ready;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic [7:0]  pixel_color = '0;
    logic        clear_start = 1'b0;
    logic [7:0]  clear_color = '0;
    logic        clear_done;
    logic        busy;
    logic        mem_req;
    logic [18:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    logic [18:0] wr_addr [$];
    logic [7:0]  wr_data [$];

    fb_pixel_writer #(.H_RES(H_RES), .V_RES(V_RES), .FIFO_DEPTH(8), .COLOR_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .DrawX(DrawX), .DrawY(DrawY), .pixel_color(pixel_color),
        .clear_start(clear_start), .clear_color(clear_color), .clear_done(clear_done),
        .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack)
    );

    always #5 Clk = ~Clk;

    // Log completed writes and clear_done cycles mid-cycle, after inputs have settled.
    always @(negedge Clk) begin
        #1;
        if (!Reset && mem_req && mem_ack) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
        if (clear_done) done_cnt++;
    end

    task automatic send_pixel(input int x, input int y, input logic [7:0] c);
        int t;
        @(negedge Clk);
        DrawX = 10'(x); DrawY = 10'(y); pixel_color = c; pixel_valid = 1'b1;
        t = 0;
        while (!pixel_ready && t < 100) begin
            @(negedge Clk);
            t++;
        end
        @(posedge Clk);
        #1 pixel_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        @(negedge Clk);
        while (busy && t < 500) begin
            @(negedge Clk);
            t++;
        end
        repeat (2) @(negedge Clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_idle: busy=%b required 0", name, busy);
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if ({pixel_ready, mem_req, mem_addr, mem_wdata, clear_done, busy} !== {1'b1, 1'b0, 19'd0, 8'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_outputs: ready=%b req=%b addr=%0d wdata=%h done=%b busy=%b required 1 0 0 00 0 0",
                     pixel_ready, mem_req, mem_addr, mem_wdata, clear_done, busy);
        end
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_single_pixel;
        int base;
        base = wr_addr.size();
        mem_ack = 1'b1;
        DrawX = 10'd20; DrawY = 10'd20; pixel_color = 8'hA5; pixel_valid = 1'b1;
        @(negedge Clk);
        pixel_valid = 1'b0;
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL single_req_early: mem_req=%b required 0", mem_req);
        end
        @(negedge Clk);
        n_cmp++;
        if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 19'd12820, 8'hA5}) begin
            n_bad++;
            $display("FAIL single_req: req=%b addr=%0d data=%h required 1 12820 a5", mem_req, mem_addr, mem_wdata);
        end
        wait_idle("single");
        n_cmp++;
        if (wr_addr.size() - base != 1) begin
            n_bad++;
            $display("FAIL single_count: writes=%0d required 1", wr_addr.size() - base);
        end
    endtask

    task automatic test_backpressure;
        int base, idx;
        logic acc;
        base = wr_addr.size();
        mem_ack = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge Clk);
            if (cyc == 15) begin
                n_cmp++;
                if (idx != 9 || pixel_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bp_stall: accepted=%0d ready=%b required 9 0", idx, pixel_ready);
                end
                mem_ack = 1'b1;
            end
            pixel_valid = (idx < 10);
            DrawX = 10'(idx); DrawY = 10'd1; pixel_color = 8'(8'h10 + idx);
            acc = pixel_valid && pixel_ready;
            @(posedge Clk);
            if (acc) idx++;
        end
        pixel_valid = 1'b0;
        wait_idle("bp");
        n_cmp++;
        if (wr_addr.size() - base != 10) begin
            n_bad++;
            $display("FAIL bp_count: writes=%0d required 10", wr_addr.size() - base);
        end
        for (int i = 0; i < 10 && base + i < wr_addr.size(); i++) begin
            n_cmp++;
            if (wr_addr[base+i] !== 19'(640 + i) || wr_data[base+i] !== 8'(8'h10 + i)) begin
                n_bad++;
                $display("FAIL bp_order[%0d]: addr=%0d data=%h required %0d %h",
                         i, wr_addr[base+i], wr_data[base+i], 640 + i, 8'(8'h10 + i));
            end
        end
    endtask

    task automatic test_out_of_range;
        int base;
        base = wr_addr.size();
        mem_ack = 1'b1;
        send_pixel(640, 0, 8'h11);
        send_pixel(0, 48, 8'h22);
        send_pixel(0, 480, 8'h33);
        send_pixel(639, 47, 8'hC3);
        wait_idle("oor");
        n_cmp++;
        if (wr_addr.size() - base != 1) begin
            n_bad++;
            $display("FAIL oor_count: writes=%0d required 1", wr_addr.size() - base);
        end else begin
            n_cmp++;
            if (wr_addr[base] !== 19'd30719 || wr_data[base] !== 8'hC3) begin
                n_bad++;
                $display("FAIL oor_write: addr=%0d data=%h required 30719 c3", wr_addr[base], wr_data[base]);
            end
        end
    endtask

    task automatic test_clear;
        int base, dbase, bad_ix, t;
        logic ready_seen;
        base = wr_addr.size();
        dbase = done_cnt;
        ready_seen = 1'b0;
        mem_ack = 1'b1;
        @(negedge Clk);
        clear_color = 8'h00; clear_start = 1'b1;
        @(negedge Clk);
        clear_start = 1'b0;
        t = 0;
        while (done_cnt == dbase && t < NPIX + 100) begin
            @(negedge Clk);
            if (mem_req && pixel_ready) ready_seen = 1'b1;
            t++;
        end
        repeat (4) @(negedge Clk);
        n_cmp++;
        if (done_cnt - dbase != 1) begin
            n_bad++;
            $display("FAIL clear_done_pulses: pulses=%0d required 1", done_cnt - dbase);
        end
        n_cmp++;
        if (ready_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_ready: pixel_ready seen=%b required 0", ready_seen);
        end
        n_cmp++;
        if (wr_addr.size() - base != NPIX) begin
            n_bad++;
            $display("FAIL clear_count: writes=%0d required %0d", wr_addr.size() - base, NPIX);
        end
        bad_ix = -1;
        for (int i = 0; i < int'(NPIX) && base + i < wr_addr.size(); i++)
            if (bad_ix < 0 && (wr_addr[base+i] !== 19'(i) || wr_data[base+i] !== 8'h00)) bad_ix = i;
        n_cmp++;
        if (bad_ix >= 0) begin
            n_bad++;
            $display("FAIL clear_seq[%0d]: addr=%0d data=%h required %0d 00",
                     bad_ix, wr_addr[base+bad_ix], wr_data[base+bad_ix], bad_ix);
        end
        n_cmp++;
        if (busy !== 1'b0 || pixel_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_after: busy=%b ready=%b required 0 1", busy, pixel_ready);
        end
    endtask

    task automatic test_reset_mid_clear;
        int base, dbase, bad_ix, t;
        base = wr_addr.size();
        dbase = done_cnt;
        mem_ack = 1'b1;
        @(negedge Clk);
        clear_color = 8'h3C; clear_start = 1'b1;
        @(negedge Clk);
        clear_start = 1'b0;
        t = 0;
        while (mem_addr != 19'd1000 && t < 2000) begin
            @(negedge Clk);
            t++;
        end
        Reset = 1'b1;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0 || mem_addr !== 19'd0) begin
            n_bad++;
            $display("FAIL rmc_async: req=%b addr=%0d required 0 0", mem_req, mem_addr);
        end
        repeat (3) @(negedge Clk);
        n_cmp++;
        if (done_cnt != dbase) begin
            n_bad++;
            $display("FAIL rmc_no_done: pulses=%0d required 0", done_cnt - dbase);
        end
        n_cmp++;
        if (wr_addr.size() - base != 1000) begin
            n_bad++;
            $display("FAIL rmc_count: writes=%0d required 1000", wr_addr.size() - base);
        end
        bad_ix = -1;
        for (int i = 0; i < 1000 && base + i < wr_addr.size(); i++)
            if (bad_ix < 0 && (wr_addr[base+i] !== 19'(i) || wr_data[base+i] !== 8'h3C)) bad_ix = i;
        n_cmp++;
        if (bad_ix >= 0) begin
            n_bad++;
            $display("FAIL rmc_seq[%0d]: addr=%0d data=%h required %0d 3c",
                     bad_ix, wr_addr[base+bad_ix], wr_data[base+bad_ix], bad_ix);
        end
        Reset = 1'b0;
        base = wr_addr.size();
        send_pixel(5, 3, 8'h77);
        wait_idle("rmc");
        n_cmp++;
        if (wr_addr.size() - base != 1 || wr_addr[base] !== 19'd1925 || wr_data[base] !== 8'h77) begin
            n_bad++;
            $display("FAIL rmc_fresh: writes=%0d first addr=%0d required 1 write at 1925 data 77",
                     wr_addr.size() - base, (wr_addr.size() > base) ? wr_addr[base] : 19'd0);
        end
    endtask

    task automatic test_dedup;
        int base, exp_n;
        base = wr_addr.size();
        mem_ack = 1'b1;
`ifdef FB_DEDUP_EN
        exp_n = 2;
`else
        exp_n = 3;
`endif
        send_pixel(40, 20, 8'h01);
        send_pixel(40, 20, 8'h02);
        send_pixel(20, 40, 8'h03);
        wait_idle("dedup");
        n_cmp++;
        if (wr_addr.size() - base != exp_n) begin
            n_bad++;
            $display("FAIL dedup_count: writes=%0d required %0d", wr_addr.size() - base, exp_n);
        end else begin
            n_cmp++;
            if (wr_addr[base] !== 19'd12840 || wr_addr[base+exp_n-1] !== 19'd25620) begin
                n_bad++;
                $display("FAIL dedup_addr: first=%0d last=%0d required 12840 25620",
                         wr_addr[base], wr_addr[base+exp_n-1]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single_pixel;
        test_backpressure;
        test_out_of_range;
        test_dedup;
        test_clear;
        test_reset_mid_clear;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
